truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

- Sequencer that exercises one 3-input combinational logic function (for example the 0x38 gate) over all eight input rows, {in1,in2,in3} = 000 through 111.
- For each row it applies the input vector, waits a settle window, samples the function output several times, and packs the results into an 8-bit truth-table signature.
- Compares the signature against an expected code and reports pass/fail.
- Sits between the test/config controller and the logic-function instance it drives; the function itself is external.

## Interface
Parameters:
- SETTLE_CYCLES, 4: idle cycles after applying a row before sampling; legal range 0..255.
- N_SAMPLES, 3: consecutive output samples taken per row; legal range 1..15.
- EXPECTED, 8'h38: expected signature.

Ports:
- clk, in, 1: rising-edge clock; the only clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: request a sweep; sampled only in IDLE.
- abort, in, 1: cancel the sweep in progress.
- fn_out, in, 1: output of the logic function, synchronous to clk.
- vec, out, 3: {in1,in2,in3} driven to the function.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse at sweep completion.
- signature, out, 8: captured truth table.
- unstable, out, 8: per-row flag set when the samples for that row disagreed.
- pass, out, 1: high when signature == EXPECTED and unstable == 0.

## Operation
State machine: IDLE, APPLY, SETTLE, SAMPLE, DONE.
- IDLE: when start=1, go to APPLY. In the same transition:
  - set row to 0;
  - clear signature, unstable and pass.
- APPLY: one cycle with vec = row. Next state is SETTLE if SETTLE_CYCLES > 0, otherwise SAMPLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: lasts exactly N_SAMPLES cycles, sampling fn_out once per cycle.
  - Row bit position is 7−row, so row 000 is the MSB. The 0x38 function therefore yields 8'h38.
  - If all samples are equal, signature[7−row] = that value.
  - If any sample differs, set unstable[7−row] = 1 and signature[7−row] = the last sample.
  - Then: if row == 7, go to DONE; otherwise row increments and the state returns to APPLY.
- DONE: one cycle.
  - done = 1.
  - pass = (signature == EXPECTED) && (unstable == 0).
  - Then go to IDLE.

Output holding:
- signature, unstable and pass hold their values in IDLE until the next accepted start.
- vec holds the last row driven until the next sweep, then returns to 0 at the APPLY of row 0.

Boundary behaviour:
- start while busy: ignored; no queueing.
- abort in any non-IDLE state: next state is IDLE; vec = 0; signature, unstable and pass are cleared; done does not pulse. abort takes priority over every other transition.
- abort in IDLE: no effect.
- start and abort high together in IDLE: start is accepted.
- Reset mid-sweep: immediate return to the reset values below; no done pulse.

Reset values:
- state = IDLE
- vec = 3'b000
- busy = 0
- done = 0
- signature = 8'h00
- unstable = 8'h00
- pass = 0

## Timing
- All outputs are registered.
- start is accepted at clock edge k; busy = 1 from edge k+1.
- Each row takes R = 1 + SETTLE_CYCLES + N_SAMPLES cycles.
- done is high during cycle k + 1 + 8R. With the defaults (R = 8) this is cycle k+65.
- busy falls at the same edge at which done falls.
- pass and signature are final and valid in the same cycle as done.
- A new start can be accepted in the cycle after done.
- Sample counter is 4 bits; settle counter is 8 bits. Counters reset to 0 on every state entry. There is no wrap-around beyond the terminal count.

## Structure
- Package tts_pkg holds:
  - the state enum sweep_state_t (IDLE, APPLY, SETTLE, SAMPLE, DONE);
  - constants NUM_ROWS = 8 and ROW_W = 3;
  - the bit-position function row_bit(row) = 7 − row.
- One sub-module, tts_sample_checker:
  - accumulates N_SAMPLES samples of fn_out;
  - outputs value and stable;
  - is cleared by a first-sample strobe.
- Counters and the FSM live in the top level.

## Test plan
- Correct 0x38 function attached, defaults, start pulse → done at k+65, signature = 8'h38, unstable = 0, pass = 1.
- Function model returning 0x3C pattern (row 5 = 1) → signature = 8'h3C, pass = 0.
- fn_out toggled during the SAMPLE window of row 4 → unstable = 8'h08, pass = 0.
- abort asserted during SETTLE of row 3 → next cycle IDLE, vec = 0, no done pulse; a following start completes a full sweep normally.
- rst_n low mid-sweep, then start pulsed again while busy → outputs take their reset values; start pulses during the new sweep are ignored (exactly one done).
- SETTLE_CYCLES = 0, N_SAMPLES = 1 → R = 2, done at k+17, signature = 8'h38.

Source files
------------

// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tts_pkg;

    localparam int unsigned NUM_ROWS = 8;
    localparam int unsigned ROW_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        DONE
    } sweep_state_t;

    // Row 000 lands in the MSB of the signature.
    function automatic logic [ROW_W-1:0] row_bit(input logic [ROW_W-1:0] row);
        return ROW_W'(NUM_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tts_sample_checker.sv
// Accumulates the samples of one row; value/stable already include the current sample.
module tts_sample_checker (
    input  logic clk,
    input  logic rst_n,
    input  logic sample_en,
    input  logic first,
    input  logic fn_out,
    output logic value_c,
    output logic stable_c
);

    logic last_q;
    logic stable_q;

    assign value_c  = fn_out;
    assign stable_c = first ? 1'b1 : (stable_q && (fn_out == last_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q   <= 1'b0;
            stable_q <= 1'b0;
        end else if (sample_en) begin
            last_q   <= fn_out;
            stable_q <= stable_c;
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a 3-input function through all eight rows, captures its truth table
// and compares it with an expected signature.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned N_SAMPLES     = 3,
    parameter logic [7:0]  EXPECTED      = 8'h38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             fn_out,
    output logic [ROW_W-1:0] vec,
    output logic             busy,
    output logic             done,
    output logic [7:0]       signature,
    output logic [7:0]       unstable,
    output logic             pass
);

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [3:0]       SAMPLE_LAST = 4'(N_SAMPLES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST    = ROW_W'(NUM_ROWS - 1);

    sweep_state_t     state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [7:0]       settle_cnt_q, settle_cnt_d;
    logic [3:0]       samp_cnt_q, samp_cnt_d;
    logic [ROW_W-1:0] vec_q, vec_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       sig_q, sig_d;
    logic [7:0]       unst_q, unst_d;
    logic             pass_q, pass_d;
    logic [ROW_W-1:0] bit_idx;
    logic             sample_en;
    logic             first_sample;
    logic             chk_value;
    logic             chk_stable;

    assign sample_en    = (state_q == SAMPLE);
    assign first_sample = sample_en && (samp_cnt_q == 4'd0);

    tts_sample_checker u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .first     (first_sample),
        .fn_out    (fn_out),
        .value_c   (chk_value),
        .stable_c  (chk_stable)
    );

    // Next-state and registered-output logic; abort overrides everything at the end.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        settle_cnt_d = settle_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        vec_d        = vec_q;
        sig_d        = sig_q;
        unst_d       = unst_q;
        pass_d       = pass_q;
        done_d       = 1'b0;
        busy_d       = (state_q != IDLE);
        bit_idx      = row_bit(row_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = APPLY;
                    row_d        = '0;
                    settle_cnt_d = '0;
                    samp_cnt_d   = '0;
                    sig_d        = '0;
                    unst_d       = '0;
                    pass_d       = 1'b0;
                end
            end
            APPLY: begin
                vec_d        = row_q;
                settle_cnt_d = '0;
                samp_cnt_d   = '0;
                state_d      = (SETTLE_CYCLES != 0) ? SETTLE : SAMPLE;
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d      = SAMPLE;
                    settle_cnt_d = '0;
                    samp_cnt_d   = '0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end
            SAMPLE: begin
                if (samp_cnt_q == SAMPLE_LAST) begin
                    sig_d[bit_idx]  = chk_value;
                    unst_d[bit_idx] = ~chk_stable;
                    samp_cnt_d      = '0;
                    if (row_q == ROW_LAST) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = APPLY;
                    end
                end else begin
                    samp_cnt_d = samp_cnt_q + 4'd1;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (sig_q == EXPECTED) && (unst_q == 8'h00);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d      = IDLE;
            settle_cnt_d = '0;
            samp_cnt_d   = '0;
            vec_d        = '0;
            sig_d        = '0;
            unst_d       = '0;
            pass_d       = 1'b0;
            done_d       = 1'b0;
            busy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            row_q        <= '0;
            settle_cnt_q <= '0;
            samp_cnt_q   <= '0;
            vec_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            sig_q        <= '0;
            unst_q       <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            settle_cnt_q <= settle_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            vec_q        <= vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            sig_q        <= sig_d;
            unst_q       <= unst_d;
            pass_q       <= pass_d;
        end
    end

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign signature = sig_q;
    assign unstable  = unst_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench: a truth-table function model drives the sweeper and results
// are compared with signatures derived from the table and injected glitches.
module tb_truth_table_sweeper;

    localparam int S = 4;
    localparam int N = 3;
    localparam int R = 1 + S + N;
    localparam int RF = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, fn_out;
    logic [2:0] vec;
    logic       busy, done, pass;
    logic [7:0] signature, unstable;

    logic       start_f, fn_f;
    logic       abort_f = 1'b0;
    logic [2:0] vec_f;
    logic       busy_f, done_f, pass_f;
    logic [7:0] sig_f, unst_f;

    logic [7:0]  tt = 8'h00;
    logic [7:0]  tt_f = 8'h00;
    bit          glitch_en = 1'b0;
    int unsigned glitch_row = 0;
    int unsigned glitch_s = 0;
    int          cyc = 0;
    int          k = 0;
    int          done_cnt = 0;
    int          done_cnt_f = 0;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (done)   done_cnt   <= done_cnt + 1;
        if (done_f) done_cnt_f <= done_cnt_f + 1;
    end

    // Function under test: truth table indexed with row 000 at bit 7, plus an optional one-cycle glitch.
    always_comb begin
        fn_out = tt[7 - int'(vec)];
        if (glitch_en && (cyc == k + int'(glitch_row) * R + 1 + S + int'(glitch_s)))
            fn_out = ~fn_out;
        fn_f = tt_f[7 - int'(vec_f)];
    end

    truth_table_sweeper #(.SETTLE_CYCLES(S), .N_SAMPLES(N), .EXPECTED(8'h38)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .fn_out(fn_out),
        .vec(vec), .busy(busy), .done(done), .signature(signature),
        .unstable(unstable), .pass(pass)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(0), .N_SAMPLES(1), .EXPECTED(8'h38)) dut_fast (
        .clk(clk), .rst_n(rst_n), .start(start_f), .abort(abort_f), .fn_out(fn_f),
        .vec(vec_f), .busy(busy_f), .done(done_f), .signature(sig_f),
        .unstable(unst_f), .pass(pass_f)
    );

    // Full sweep on the default instance; caller must be at a negedge.
    task automatic run_sweep(input logic [7:0] table_v, input bit gl, input int unsigned grow,
                             input int unsigned gs, input bit pulse, input string name);
        logic [7:0] exp_sig, exp_unst;
        logic       exp_pass;
        int         d0;
        bit         seen;
        exp_sig  = table_v;
        exp_unst = 8'h00;
        if (gl) begin
            exp_unst[7 - grow] = 1'b1;
            if (gs == N - 1) exp_sig[7 - grow] = ~table_v[7 - grow];
        end
        exp_pass   = (exp_sig == 8'h38) && (exp_unst == 8'h00);
        tt         = table_v;
        glitch_en  = gl;
        glitch_row = grow;
        glitch_s   = gs;
        d0         = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        k     = cyc;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL %s busy_at_k: got %b want 0", name, busy); end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL %s busy_at_k1: got %b want 1", name, busy); end
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            start = pulse && ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_timeout: no done within 200 cycles", name);
        end else begin
            tests++;
            if (cyc != k + 1 + 8 * R) begin
                fails++; $display("FAIL %s done_cycle: got k+%0d want k+%0d", name, cyc - k, 1 + 8 * R);
            end
            tests++;
            if (signature !== exp_sig) begin
                fails++; $display("FAIL %s signature: got %h want %h", name, signature, exp_sig);
            end
            tests++;
            if (unstable !== exp_unst) begin
                fails++; $display("FAIL %s unstable: got %h want %h", name, unstable, exp_unst);
            end
            tests++;
            if (pass !== exp_pass) begin
                fails++; $display("FAIL %s pass: got %b want %b", name, pass, exp_pass);
            end
            tests++;
            if (busy !== 1'b1) begin
                fails++; $display("FAIL %s busy_with_done: got %b want 1", name, busy);
            end
        end
        @(negedge clk);
        glitch_en = 1'b0;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL %s after_done: done=%b busy=%b want 0 0", name, done, busy);
        end
        tests++;
        if (done_cnt - d0 != 1) begin
            fails++; $display("FAIL %s done_count: got %0d want 1", name, done_cnt - d0);
        end
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (vec !== 3'b000 || busy !== 1'b0 || done !== 1'b0 || signature !== 8'h00 ||
            unstable !== 8'h00 || pass !== 1'b0) begin
            fails++;
            $display("FAIL %s: vec=%b busy=%b done=%b sig=%h unst=%h pass=%b want all zero",
                     name, vec, busy, done, signature, unstable, pass);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; start_f = 1'b0;
        repeat (2) @(negedge clk);
        check_zero("reset_values");
        tests++;
        if (busy_f !== 1'b0 || sig_f !== 8'h00) begin
            fails++; $display("FAIL reset_fast: busy=%b sig=%h want 0 00", busy_f, sig_f);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_golden;
        run_sweep(8'h38, 1'b0, 0, 0, 1'b0, "golden_38");
    endtask

    task automatic test_wrong_function;
        run_sweep(8'h3C, 1'b0, 0, 0, 1'b0, "func_3c");
    endtask

    task automatic test_glitch_row4;
        run_sweep(8'h38, 1'b1, 4, 1, 1'b0, "glitch_row4");
    endtask

    task automatic test_abort;
        int d0;
        tt = 8'h38; glitch_en = 1'b0;
        d0 = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        k = cyc;
        start = 1'b0;
        while (cyc < k + 3 * R + 2) @(negedge clk);
        tests++;
        if (signature !== (tt & 8'hE0)) begin
            fails++; $display("FAIL abort_partial_sig: got %h want %h", signature, tt & 8'hE0);
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_zero("abort_clears");
        repeat (80) @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done_cnt != d0) begin
            fails++; $display("FAIL abort_idle: busy=%b dones=%0d want 0 0", busy, done_cnt - d0);
        end
        run_sweep(8'h38, 1'b0, 0, 0, 1'b0, "after_abort");
    endtask

    task automatic test_reset_mid;
        tt = 8'h38;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_sweep");
        @(negedge clk);
        rst_n = 1'b1;
        run_sweep(8'h38, 1'b0, 0, 0, 1'b1, "restart_ignore_start");
    endtask

    task automatic test_random_back_to_back;
        logic [7:0]  tab;
        bit          gl;
        int unsigned grow, gs;
        for (int i = 0; i < 8; i++) begin
            tab  = ($urandom_range(0, 3) == 0) ? 8'h38 : 8'($urandom);
            gl   = 1'($urandom_range(0, 1));
            grow = $urandom_range(0, 7);
            gs   = $urandom_range(0, N - 1);
            run_sweep(tab, gl, grow, gs, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    task automatic test_fast;
        int  kf, d0;
        bit  seen;
        for (int i = 0; i < 4; i++) begin
            tt_f = (i == 0) ? 8'h38 : 8'($urandom);
            d0 = done_cnt_f;
            start_f = 1'b1;
            @(posedge clk);
            #1;
            kf = cyc;
            start_f = 1'b0;
            seen = 1'b0;
            for (int j = 0; j < 60; j++) begin
                @(negedge clk);
                if (done_f === 1'b1) begin seen = 1'b1; break; end
            end
            tests++;
            if (!seen) begin
                fails++; $display("FAIL fast_timeout: no done within 60 cycles");
            end else begin
                tests++;
                if (cyc != kf + 1 + 8 * RF) begin
                    fails++; $display("FAIL fast_done_cycle: got k+%0d want k+%0d", cyc - kf, 1 + 8 * RF);
                end
                tests++;
                if (sig_f !== tt_f || unst_f !== 8'h00 || pass_f !== (tt_f == 8'h38)) begin
                    fails++;
                    $display("FAIL fast_result: sig=%h unst=%h pass=%b want %h 00 %b",
                             sig_f, unst_f, pass_f, tt_f, tt_f == 8'h38);
                end
            end
            @(negedge clk);
            tests++;
            if (done_cnt_f - d0 != 1) begin
                fails++; $display("FAIL fast_done_count: got %0d want 1", done_cnt_f - d0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_wrong_function();
        test_glitch_row4();
        test_abort();
        test_reset_mid();
        test_random_back_to_back();
        test_fast();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
